imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: accepts a stream of 16-bit instruction words and writes them into instruction memory at consecutive byte addresses.
- The fetch stage is the reader on this interface. It reads with PC stepping by 2.
- Holds the processor in reset through `cpu_hold` until a load completes cleanly.
- Sits between the program source (bench or host link) and the instruction memory write port.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams 16-bit instruction words into instruction memory at
// consecutive byte addresses and holds the CPU in reset until a load completes.
// Optional trailing-checksum beat enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd2,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_write_enable,
  output logic [15:0] mem_write_data,
  output logic [31:0] mem_write_addr,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] wa_q, wa_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  // Word index MAX_WORDS-1 is the last one that fits in a load.
  logic last_slot;
  assign last_slot = (32'(cnt_q) == MAX_WORDS - 1);

  // in_ready is the only output decoded straight from the state register.
  always_comb begin
    in_ready = (state_q == StLoad);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_q == StCheck) in_ready = 1'b1;
`endif
  end

  // Next-state, write strobe and status flags.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wd_d    = wd_q;
    wa_d    = wa_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StLoad;
          ptr_d   = BASE_ADDR;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        if (in_valid) begin
          we_d  = 1'b1;
          wd_d  = in_data;
          wa_d  = ptr_q;
          ptr_d = ptr_q + ADDR_STEP;
          cnt_d = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          // in_last takes priority over the overflow condition.
          if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else if (last_slot) begin
            state_d = StError;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        // Checksum beat: compared only, never written, in_last ignored.
        if (in_valid) state_d = (in_data == sum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
    // Status flags follow the state being entered so they move with it.
    done_d  = (state_d == StDone);
    error_d = (state_d == StError);
    hold_d  = (state_d != StDone);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= BASE_ADDR;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      wa_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_write_enable = we_q;
  assign mem_write_data   = wd_q;
  assign mem_write_addr   = wa_q;
  assign word_count       = cnt_q;
  assign done             = done_q;
  assign error            = error_q;
  assign cpu_hold         = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: hand-written vector table for the load scenarios,
// then random stimulus checked against a transaction-level model.
module tb_imem_loader;

  localparam logic [31:0] TbBase = 32'h0000_0020;
  localparam logic [31:0] TbStep = 32'd2;
  localparam int unsigned TbMaxw = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [15:0] in_data;
  logic        in_ready, mem_write_enable, cpu_hold, done, error;
  logic [15:0] mem_write_data, word_count;
  logic [31:0] mem_write_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR(TbBase),
    .ADDR_STEP(TbStep),
    .MAX_WORDS(TbMaxw)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_write_addr   (mem_write_addr),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error),
    .word_count       (word_count)
  );

  // Reference model: load phase plus word count; address is BASE + n*STEP.
  localparam int MIdle = 0, MLoad = 1, MCheck = 2, MDone = 3, MErr = 4;
  int          m_st  = MIdle;
  int unsigned m_n   = 0;
  logic [15:0] m_sum = '0;
  bit          m_we  = 1'b0;
  logic [15:0] m_wd  = '0;
  logic [31:0] m_wa  = '0;

  task automatic model_edge(input bit r, input bit s, input bit v,
                            input logic [15:0] d, input bit l);
    m_we = 1'b0;
    if (!r) begin
      m_st = MIdle; m_n = 0; m_sum = '0; m_wd = '0; m_wa = '0;
      return;
    end
    case (m_st)
      MIdle, MDone, MErr: if (s) begin m_st = MLoad; m_n = 0; m_sum = '0; end
      MLoad: if (v) begin
        m_we  = 1'b1;
        m_wd  = d;
        m_wa  = TbBase + 32'(m_n) * TbStep;
        m_n   = m_n + 1;
        m_sum = m_sum + d;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (l) m_st = MCheck;
`else
        if (l) m_st = MDone;
`endif
        else if (m_n == TbMaxw) m_st = MErr;
      end
      MCheck: if (v) m_st = (d == m_sum) ? MDone : MErr;
      default: m_st = MIdle;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge, advance model, settle.
  task automatic edge_step(input bit r, input bit s, input bit v,
                           input logic [15:0] d, input bit l);
    reset = r; start = s; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    model_edge(r, s, v, d, l);
    #1;
  endtask

  typedef struct {
    bit r, s, v; logic [15:0] d; bit l;
    bit we; logic [31:0] a; logic [15:0] wd; logic [15:0] cnt;
    bit dn, er, hd, rd;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit r, bit s, bit v, logic [15:0] d, bit l,
                              bit we, logic [31:0] a, logic [15:0] wd, logic [15:0] cnt,
                              bit dn, bit er, bit hd, bit rd);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.d = d; x.l = l;
    x.we = we; x.a = a; x.wd = wd; x.cnt = cnt;
    x.dn = dn; x.er = er; x.hd = hd; x.rd = rd;
    vecs.push_back(x);
  endfunction

  initial begin
    //  r  s  v  data     l   we addr   wdata    cnt dn er hd rd
    // Reset, then basic back-to-back load.
    add(0, 0, 0, 16'h0,    0,  0, 32'h0,  16'h0,    0, 0, 0, 1, 0);
    add(1, 0, 0, 16'h0,    0,  0, 32'h0,  16'h0,    0, 0, 0, 1, 0);
    add(1, 1, 0, 16'h0,    0,  0, 32'h0,  16'h0,    0, 0, 0, 1, 1);
    add(1, 0, 1, 16'h1111, 0,  1, 32'h20, 16'h1111, 1, 0, 0, 1, 1);
    add(1, 0, 1, 16'h2222, 0,  1, 32'h22, 16'h2222, 2, 0, 0, 1, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 0, 1, 16'h3333, 1,  1, 32'h24, 16'h3333, 3, 0, 0, 1, 1);
    add(1, 0, 1, 16'h6666, 0,  0, 32'h24, 16'h3333, 3, 1, 0, 0, 0);
`else
    add(1, 0, 1, 16'h3333, 1,  1, 32'h24, 16'h3333, 3, 1, 0, 0, 0);
`endif
    add(1, 0, 1, 16'h4444, 0,  0, 32'h24, 16'h3333, 3, 1, 0, 0, 0);
    // Reload with gaps between words.
    add(1, 1, 0, 16'h0,    0,  0, 32'h24, 16'h3333, 0, 0, 0, 1, 1);
    add(1, 0, 1, 16'hAAAA, 0,  1, 32'h20, 16'hAAAA, 1, 0, 0, 1, 1);
    add(1, 0, 0, 16'h5555, 0,  0, 32'h20, 16'hAAAA, 1, 0, 0, 1, 1);
    add(1, 0, 0, 16'h5555, 1,  0, 32'h20, 16'hAAAA, 1, 0, 0, 1, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 0, 1, 16'hBBBB, 1,  1, 32'h22, 16'hBBBB, 2, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0000, 1,  0, 32'h22, 16'hBBBB, 2, 0, 1, 1, 0);
`else
    add(1, 0, 1, 16'hBBBB, 1,  1, 32'h22, 16'hBBBB, 2, 1, 0, 0, 0);
`endif
    // Overflow: four unmarked words fill the load, fifth is refused.
    add(1, 1, 0, 16'h0,    0,  0, 32'h22, 16'hBBBB, 0, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0001, 0,  1, 32'h20, 16'h0001, 1, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0002, 0,  1, 32'h22, 16'h0002, 2, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0003, 0,  1, 32'h24, 16'h0003, 3, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0004, 0,  1, 32'h26, 16'h0004, 4, 0, 1, 1, 0);
    add(1, 0, 1, 16'h0005, 0,  0, 32'h26, 16'h0004, 4, 0, 1, 1, 0);
    add(1, 0, 1, 16'h0005, 1,  0, 32'h26, 16'h0004, 4, 0, 1, 1, 0);
    // Mid-load reset, then restart from BASE.
    add(1, 1, 0, 16'h0,    0,  0, 32'h26, 16'h0004, 0, 0, 0, 1, 1);
    add(1, 0, 1, 16'h7001, 0,  1, 32'h20, 16'h7001, 1, 0, 0, 1, 1);
    add(1, 0, 1, 16'h7002, 0,  1, 32'h22, 16'h7002, 2, 0, 0, 1, 1);
    add(0, 0, 1, 16'h7003, 0,  0, 32'h0,  16'h0,    0, 0, 0, 1, 0);
    add(1, 1, 0, 16'h0,    0,  0, 32'h0,  16'h0,    0, 0, 0, 1, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(1, 0, 1, 16'h7004, 1,  1, 32'h20, 16'h7004, 1, 0, 0, 1, 1);
    add(1, 0, 1, 16'h7004, 0,  0, 32'h20, 16'h7004, 1, 1, 0, 0, 0);
`else
    add(1, 0, 1, 16'h7004, 1,  1, 32'h20, 16'h7004, 1, 1, 0, 0, 0);
`endif

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;

    foreach (vecs[i]) begin
      edge_step(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].l);
      chk("vec_we",    32'(mem_write_enable), 32'(vecs[i].we));
      chk("vec_addr",  mem_write_addr,        vecs[i].a);
      chk("vec_data",  32'(mem_write_data),   32'(vecs[i].wd));
      chk("vec_count", 32'(word_count),       32'(vecs[i].cnt));
      chk("vec_done",  32'(done),             32'(vecs[i].dn));
      chk("vec_error", 32'(error),            32'(vecs[i].er));
      chk("vec_hold",  32'(cpu_hold),         32'(vecs[i].hd));
      chk("vec_ready", 32'(in_ready),         32'(vecs[i].rd));
    end

    // Random traffic against the model; model state is already in step.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v, l;
      logic [15:0] d;
      r = ($urandom_range(59, 0) != 0);
      s = ($urandom_range(7, 0) == 0);
      v = ($urandom_range(1, 0) == 1);
      l = ($urandom_range(3, 0) == 0);
      d = 16'($urandom);
      // Occasionally offer the correct checksum so CHECK can reach DONE.
      if (m_st == MCheck && $urandom_range(1, 0) == 1) d = m_sum;
      edge_step(r, s, v, d, l);
      chk("rnd_we",    32'(mem_write_enable), 32'(m_we));
      chk("rnd_addr",  mem_write_addr,        m_wa);
      chk("rnd_data",  32'(mem_write_data),   32'(m_wd));
      chk("rnd_count", 32'(word_count),       m_n);
      chk("rnd_done",  32'(done),             32'(m_st == MDone));
      chk("rnd_error", 32'(error),            32'(m_st == MErr));
      chk("rnd_hold",  32'(cpu_hold),         32'(m_st != MDone));
      chk("rnd_ready", 32'(in_ready),         32'(m_st == MLoad || m_st == MCheck));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
